// File: rtl/mem_pkg.sv
// Shared types and widths for the memory issue queue and its op buffer.
package mem_pkg;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 3;
  localparam int ROB_W  = 2;

  typedef struct packed {
    logic              is_store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob_idx;
  } mem_op_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} miq_state_t;
endpackage

// File: rtl/mem_op_fifo.sv
// Circular buffer of pending memory ops; flush drops every unissued entry.
module mem_op_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  mem_op_t          push_op,
  output mem_op_t          head_op,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  mem_op_t          entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !flush) entries[tail] <= push_op;
  end

  assign head_op = entries[head];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue in front of the memory unit, one op in flight.
// Optional performance counters are enabled by defining MEM_ISSUE_PERF_EN.
module mem_issue_queue
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic              enq_is_store,
  input  logic [ADDR_W-1:0] enq_addr,
  input  logic [DATA_W-1:0] enq_data,
  input  logic [ROB_W-1:0]  enq_rob_idx,
  input  logic              flush,
  output logic              mem_start_read,
  output logic              mem_start_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [ROB_W-1:0]  mem_rob_idx,
  input  logic              mem_busy,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [ROB_W-1:0]  mem_rob_idx_done,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ROB_W-1:0]  wb_rob_idx,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_is_store,
  output logic [CNT_W-1:0]  count,
  output logic              empty
`ifdef MEM_ISSUE_PERF_EN
  ,
  output logic [7:0]        perf_loads,
  output logic [7:0]        perf_stores,
  output logic [7:0]        perf_full_stall
`endif
);
  miq_state_t state, state_nxt;
  mem_op_t    head_op;
  mem_op_t    enq_op;
  logic       full;
  logic       issue;
  logic       capture;
  logic       release_wb;
  logic       op_is_store;
  logic       kill;

  assign enq_op    = '{is_store: enq_is_store, addr: enq_addr, data: enq_data, rob_idx: enq_rob_idx};
  assign enq_ready = !full;

  mem_op_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (enq_valid && enq_ready),
    .pop     (issue),
    .flush   (flush),
    .push_op (enq_op),
    .head_op (head_op),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    capture    = 1'b0;
    release_wb = 1'b0;
    case (state)
      IDLE: if (!empty && !mem_busy && !flush) begin
        issue     = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: if (mem_done) begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (wb_ready) begin
        release_wb = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_start_read  <= 1'b0;
      mem_start_write <= 1'b0;
      mem_addr        <= '0;
      mem_write_data  <= '0;
      mem_rob_idx     <= '0;
      op_is_store     <= 1'b0;
      kill            <= 1'b0;
      wb_valid        <= 1'b0;
      wb_rob_idx      <= '0;
      wb_data         <= '0;
      wb_is_store     <= 1'b0;
    end else begin
      mem_start_read  <= issue && !head_op.is_store;
      mem_start_write <= issue && head_op.is_store;
      if (issue) begin
        mem_addr       <= head_op.addr;
        mem_write_data <= head_op.data;
        mem_rob_idx    <= head_op.rob_idx;
        op_is_store    <= head_op.is_store;
      end
      // A flush seen any time while the op is in flight kills its data.
      if (release_wb)
        kill <= 1'b0;
      else if (flush && (state == ISSUE || state == WAIT))
        kill <= 1'b1;
      if (capture) begin
        wb_valid    <= 1'b1;
        wb_rob_idx  <= mem_rob_idx_done;
        wb_is_store <= op_is_store;
        wb_data     <= (op_is_store || kill || flush) ? '0 : mem_read_data;
      end else if (release_wb) begin
        wb_valid <= 1'b0;
      end
    end
  end

`ifdef MEM_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads      <= '0;
      perf_stores     <= '0;
      perf_full_stall <= '0;
    end else begin
      if (issue && !head_op.is_store && perf_loads != 8'hFF)
        perf_loads <= perf_loads + 1'b1;
      if (issue && head_op.is_store && perf_stores != 8'hFF)
        perf_stores <= perf_stores + 1'b1;
      if (enq_valid && !enq_ready && perf_full_stall != 8'hFF)
        perf_full_stall <= perf_full_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue with a fixed-latency memory unit model.
module tb_mem_issue_queue;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       enq_valid, enq_ready, enq_is_store;
  logic [1:0] enq_addr, enq_rob_idx;
  logic [2:0] enq_data;
  logic       flush;
  logic       mem_start_read, mem_start_write;
  logic [1:0] mem_addr, mem_rob_idx;
  logic [2:0] mem_write_data;
  logic       mem_busy, mem_done;
  logic [2:0] mem_read_data;
  logic [1:0] mem_rob_idx_done;
  logic       wb_valid, wb_ready, wb_is_store;
  logic [1:0] wb_rob_idx;
  logic [2:0] wb_data;
  logic [2:0] count;
  logic       empty;
`ifdef MEM_ISSUE_PERF_EN
  logic [7:0] perf_loads, perf_stores, perf_full_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_is_store(enq_is_store),
    .enq_addr(enq_addr), .enq_data(enq_data), .enq_rob_idx(enq_rob_idx),
    .flush(flush),
    .mem_start_read(mem_start_read), .mem_start_write(mem_start_write),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_rob_idx(mem_rob_idx),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_read_data(mem_read_data),
    .mem_rob_idx_done(mem_rob_idx_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rob_idx(wb_rob_idx),
    .wb_data(wb_data), .wb_is_store(wb_is_store),
    .count(count), .empty(empty)
`ifdef MEM_ISSUE_PERF_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_full_stall(perf_full_stall)
`endif
  );

  // Memory unit: done pulses 5 cycles after the start cycle.
  logic [2:0] mem_arr [4];
  logic [1:0] m_addr, m_rob;
  logic [2:0] m_timer;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_busy <= 1'b0; mem_done <= 1'b0; mem_read_data <= '0;
      mem_rob_idx_done <= '0; m_timer <= '0; m_addr <= '0; m_rob <= '0;
    end else begin
      mem_done <= 1'b0;
      if (mem_start_read || mem_start_write) begin
        mem_busy <= 1'b1; m_timer <= 3'd4; m_addr <= mem_addr; m_rob <= mem_rob_idx;
        if (mem_start_write) mem_arr[mem_addr] <= mem_write_data;
      end else if (mem_busy) begin
        if (m_timer == 3'd1) begin
          mem_busy <= 1'b0; mem_done <= 1'b1;
          mem_read_data <= mem_arr[m_addr]; mem_rob_idx_done <= m_rob;
        end else begin
          m_timer <= m_timer - 3'd1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic enq(input logic st, input logic [1:0] a, input logic [2:0] d, input logic [1:0] r);
    enq_valid = 1'b1; enq_is_store = st; enq_addr = a; enq_data = d; enq_rob_idx = r;
    step();
    enq_valid = 1'b0;
  endtask

  task automatic wait_wb(input string name);
    int n = 0;
    while (!wb_valid && n < 40) begin step(); n++; end
    total++;
    if (!wb_valid) begin bad++; $display("FAIL %s timeout: wb_valid=%0b want 1", name, wb_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #1;
    total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL reset enq_ready: got %0b want 1", enq_ready); end
    total++; if (empty !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL reset empty/count: got %0b/%0d want 1/0", empty, count); end
    total++; if ({mem_start_read, mem_start_write, wb_valid, wb_data} !== 6'd0) begin bad++;
      $display("FAIL reset outputs: got %0b%0b%0b %0d want 0", mem_start_read, mem_start_write, wb_valid, wb_data); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_load();
    wb_ready = 1'b1;
    enq(1'b0, 2'd2, 3'd0, 2'd1);                       // now cycle N+1
    total++; if (count !== 3'd1 || mem_start_read !== 1'b0) begin bad++;
      $display("FAIL load n1: count=%0d start=%0b want 1/0", count, mem_start_read); end
    step();                                            // N+2 = start
    total++; if (mem_start_read !== 1'b1 || mem_addr !== 2'd2 || mem_rob_idx !== 2'd1) begin bad++;
      $display("FAIL load start: rd=%0b addr=%0d rob=%0d want 1/2/1", mem_start_read, mem_addr, mem_rob_idx); end
    step();
    total++; if (mem_start_read !== 1'b0) begin bad++; $display("FAIL load pulse width: got %0b want 0", mem_start_read); end
    repeat (4) step();                                 // start+5
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL load early wb: got %0b want 0", wb_valid); end
    step();                                            // start+6
    total++; if (wb_valid !== 1'b1 || wb_data !== 3'd2 || wb_rob_idx !== 2'd1 || wb_is_store !== 1'b0) begin bad++;
      $display("FAIL load wb: v=%0b d=%0d rob=%0d st=%0b want 1/2/1/0", wb_valid, wb_data, wb_rob_idx, wb_is_store); end
    step();
    total++; if (wb_valid !== 1'b0 || empty !== 1'b1) begin bad++;
      $display("FAIL load release: v=%0b empty=%0b want 0/1", wb_valid, empty); end
    step();
  endtask

  task automatic test_store_then_load();
    wb_ready = 1'b1;
    enq(1'b1, 2'd3, 3'd5, 2'd2);
    enq(1'b0, 2'd3, 3'd0, 2'd3);
    wait_wb("st ack");
    total++; if (wb_rob_idx !== 2'd2 || wb_is_store !== 1'b1 || wb_data !== 3'd0) begin bad++;
      $display("FAIL st ack: rob=%0d st=%0b d=%0d want 2/1/0", wb_rob_idx, wb_is_store, wb_data); end
    step();
    total++; if (mem_start_read !== 1'b0) begin bad++; $display("FAIL st->ld gap: got %0b want 0", mem_start_read); end
    step();
    total++; if (mem_start_read !== 1'b1) begin bad++; $display("FAIL st->ld resume: got %0b want 1", mem_start_read); end
    wait_wb("ld after st");
    total++; if (wb_rob_idx !== 2'd3 || wb_is_store !== 1'b0 || wb_data !== 3'd5) begin bad++;
      $display("FAIL ld after st: rob=%0d st=%0b d=%0d want 3/0/5", wb_rob_idx, wb_is_store, wb_data); end
    step(); step();
  endtask

  task automatic test_fill();
    logic [1:0] addrs [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0};
    logic [1:0] robs  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [2:0] exp_d [5] = '{3'd1, 3'd6, 3'd2, 3'd5, 3'd6};
    wb_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      enq_valid = 1'b1; enq_is_store = 1'b0; enq_addr = addrs[i]; enq_data = 3'd0; enq_rob_idx = robs[i];
      if (i == 5) begin
        total++; if (enq_ready !== 1'b0 || count !== 3'd4) begin bad++;
          $display("FAIL fill full: ready=%0b count=%0d want 0/4", enq_ready, count); end
      end
      step();
    end
    enq_valid = 1'b0;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill drop: count=%0d want 4", count); end
`ifdef MEM_ISSUE_PERF_EN
    total++; if (perf_full_stall !== 8'd1) begin bad++; $display("FAIL perf stall: got %0d want 1", perf_full_stall); end
`endif
    wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_wb("fill wb");
      total++; if (wb_rob_idx !== robs[i] || wb_data !== exp_d[i]) begin bad++;
        $display("FAIL fill order %0d: rob=%0d d=%0d want %0d/%0d", i, wb_rob_idx, wb_data, robs[i], exp_d[i]); end
      step();
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill drained: empty=%0b want 1", empty); end
    step();
  endtask

  task automatic test_hold();
    wb_ready = 1'b0;
    enq(1'b0, 2'd2, 3'd0, 2'd2);
    enq(1'b0, 2'd0, 3'd0, 2'd1);
    wait_wb("hold wb");
    for (int i = 0; i < 10; i++) begin
      total++; if (wb_valid !== 1'b1 || wb_rob_idx !== 2'd2 || wb_data !== 3'd2 || count !== 3'd1
                   || mem_start_read !== 1'b0 || mem_start_write !== 1'b0) begin bad++;
        $display("FAIL hold %0d: v=%0b rob=%0d d=%0d cnt=%0d start=%0b", i, wb_valid, wb_rob_idx, wb_data, count, mem_start_read); end
      step();
    end
    wb_ready = 1'b1;
    step();
    total++; if (wb_valid !== 1'b0 || mem_start_read !== 1'b0) begin bad++;
      $display("FAIL hold release: v=%0b start=%0b want 0/0", wb_valid, mem_start_read); end
    step();
    total++; if (mem_start_read !== 1'b1 || mem_addr !== 2'd0) begin bad++;
      $display("FAIL hold resume: start=%0b addr=%0d want 1/0", mem_start_read, mem_addr); end
    wait_wb("hold second");
    total++; if (wb_rob_idx !== 2'd1 || wb_data !== 3'd1) begin bad++;
      $display("FAIL hold second: rob=%0d d=%0d want 1/1", wb_rob_idx, wb_data); end
    step(); step();
  endtask

  task automatic test_flush();
    int starts = 0;
    wb_ready = 1'b1;
    enq(1'b0, 2'd1, 3'd0, 2'd1);
    enq(1'b0, 2'd2, 3'd0, 2'd2);
    enq(1'b0, 2'd3, 3'd0, 2'd3);                       // in-flight op now in WAIT
    flush = 1'b1;
    enq_valid = 1'b1; enq_is_store = 1'b0; enq_addr = 2'd0; enq_rob_idx = 2'd0;
    total++; if (enq_ready !== 1'b1 || count !== 3'd2) begin bad++;
      $display("FAIL flush pre: ready=%0b count=%0d want 1/2", enq_ready, count); end
    step();
    flush = 1'b0; enq_valid = 1'b0;
    total++; if (count !== 3'd0 || empty !== 1'b1) begin bad++;
      $display("FAIL flush count: count=%0d empty=%0b want 0/1", count, empty); end
    wait_wb("flush wb");
    total++; if (wb_rob_idx !== 2'd1 || wb_data !== 3'd0) begin bad++;
      $display("FAIL flush killed: rob=%0d d=%0d want 1/0", wb_rob_idx, wb_data); end
    for (int i = 0; i < 15; i++) begin
      step();
      if (mem_start_read || mem_start_write) starts++;
    end
    total++; if (starts != 0 || count !== 3'd0) begin bad++;
      $display("FAIL flush quiet: starts=%0d count=%0d want 0/0", starts, count); end
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b1;
    enq(1'b0, 2'd1, 3'd0, 2'd3);
    enq(1'b0, 2'd2, 3'd0, 2'd0);
    step(); step();                                    // first op in WAIT, second queued
    #2 rst_n = 1'b0;
    #1;
    total++; if (count !== 3'd0 || empty !== 1'b1 || enq_ready !== 1'b1) begin bad++;
      $display("FAIL rst mid queue: count=%0d empty=%0b ready=%0b", count, empty, enq_ready); end
    total++; if ({mem_start_read, mem_start_write, mem_addr, mem_rob_idx, mem_write_data, wb_valid, wb_rob_idx, wb_data, wb_is_store} !== 15'd0) begin bad++;
      $display("FAIL rst mid outputs: addr=%0d rob=%0d wbv=%0b", mem_addr, mem_rob_idx, wb_valid); end
    step();
    rst_n = 1'b1;
    step();
    enq(1'b0, 2'd2, 3'd0, 2'd2);
    step();
    total++; if (mem_start_read !== 1'b1 || mem_rob_idx !== 2'd2) begin bad++;
      $display("FAIL rst after start: rd=%0b rob=%0d want 1/2", mem_start_read, mem_rob_idx); end
    repeat (6) step();
    total++; if (wb_valid !== 1'b1 || wb_data !== 3'd2 || wb_rob_idx !== 2'd2) begin bad++;
      $display("FAIL rst after wb: v=%0b d=%0d rob=%0d want 1/2/2", wb_valid, wb_data, wb_rob_idx); end
    step();
  endtask

  initial begin
    mem_arr[0] = 3'd1; mem_arr[1] = 3'd6; mem_arr[2] = 3'd2; mem_arr[3] = 3'd0;
    enq_valid = 1'b0; enq_is_store = 1'b0; enq_addr = '0; enq_data = '0; enq_rob_idx = '0;
    flush = 1'b0; wb_ready = 1'b0; rst_n = 1'b0;
    test_reset();
    test_single_load();
    test_store_then_load();
    test_fill();
    test_hold();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
